// File: rtl/otter_pkg.sv
// Shared pipeline definitions: opcode constants, the NOP encoding, forwarding select codes
// and a register-match helper used by the hazard logic.
package otter_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    REG = 2'b00,
    MEM = 2'b01,
    WB  = 2'b10
  } fwd_sel_t;

  // x0 is excluded upstream: writesRd is never set for rd == 0.
  function automatic logic regMatch(input logic prodWr, input logic [4:0] prodRd,
                                    input logic srcUsed, input logic [4:0] srcReg);
    return prodWr && srcUsed && (prodRd == srcReg);
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Extracts register fields and producer/consumer properties from one instruction word.
module hazard_decode
  import otter_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        writesRd,
  output logic        usesRs1,
  output logic        usesRs2,
  output logic        isLoad
);

  logic [6:0] opcode;
  logic       unusedIr;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign unusedIr = ^{ir[31:25], ir[14:12]};

  assign writesRd = (opcode != OPC_BRANCH) && (opcode != OPC_STORE) && (rd != 5'd0);
  assign usesRs1  = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
  assign usesRs2  = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  assign isLoad   = (opcode == OPC_LOAD);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use / interlock stall sequencing, branch flush and EX operand forwarding.
//
// state | meaning
// RUN   | normal issue; hazards detected combinationally, a 1-cycle stall stays here
// STALL | front end held; stallCnt counts remaining held cycles, detection suppressed
module hazard_unit
  import otter_pkg::*;
#(
  parameter int FWD_EN   = 1,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      id_ir,
  input  logic [31:0]      ex_ir,
  input  logic [31:0]      mem_ir,
  input  logic [31:0]      wb_ir,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [4:0] idRd, idRs1, idRs2, exRd, exRs1, exRs2;
  logic [4:0] memRd, memRs1, memRs2, wbRd, wbRs1, wbRs2;
  logic idWr, idUses1, idUses2, idIsLoad;
  logic exWr, exUses1, exUses2, exIsLoad;
  logic memWr, memUses1, memUses2, memIsLoad;
  logic wbWr, wbUses1, wbUses2, wbIsLoad;
  logic unusedDec;

  hazard_decode uDecId (
    .ir(id_ir), .rd(idRd), .rs1(idRs1), .rs2(idRs2),
    .writesRd(idWr), .usesRs1(idUses1), .usesRs2(idUses2), .isLoad(idIsLoad)
  );
  hazard_decode uDecEx (
    .ir(ex_ir), .rd(exRd), .rs1(exRs1), .rs2(exRs2),
    .writesRd(exWr), .usesRs1(exUses1), .usesRs2(exUses2), .isLoad(exIsLoad)
  );
  hazard_decode uDecMem (
    .ir(mem_ir), .rd(memRd), .rs1(memRs1), .rs2(memRs2),
    .writesRd(memWr), .usesRs1(memUses1), .usesRs2(memUses2), .isLoad(memIsLoad)
  );
  hazard_decode uDecWb (
    .ir(wb_ir), .rd(wbRd), .rs1(wbRs1), .rs2(wbRs2),
    .writesRd(wbWr), .usesRs1(wbUses1), .usesRs2(wbUses2), .isLoad(wbIsLoad)
  );

  assign unusedDec = ^{idRd, idWr, idIsLoad, memRs1, memRs2, memUses1, memUses2,
                       wbRs1, wbRs2, wbUses1, wbUses2, wbIsLoad};

  logic matchEx, matchMem, matchWb;
  logic hazard;
  logic [1:0] stallLen;

  assign matchEx  = regMatch(exWr, exRd, idUses1, idRs1)  || regMatch(exWr, exRd, idUses2, idRs2);
  assign matchMem = regMatch(memWr, memRd, idUses1, idRs1) || regMatch(memWr, memRd, idUses2, idRs2);
  assign matchWb  = regMatch(wbWr, wbRd, idUses1, idRs1)  || regMatch(wbWr, wbRd, idUses2, idRs2);

  // The nearest producer decides the interlock length when forwarding is off.
  always_comb begin
    hazard   = 1'b0;
    stallLen = 2'd0;
    if (FWD_EN != 0) begin
      if (exIsLoad && matchEx) begin
        hazard   = 1'b1;
        stallLen = 2'(LOAD_LAT);
      end
    end else if (matchEx) begin
      hazard   = 1'b1;
      stallLen = 2'd3;
    end else if (matchMem) begin
      hazard   = 1'b1;
      stallLen = 2'd2;
    end else if (matchWb) begin
      hazard   = 1'b1;
      stallLen = 2'd1;
    end
  end

  logic [0:0] state, nextState;
  logic [1:0] stallCnt, nextCnt;
  logic       holdFront;

  always_comb begin
    nextState   = state;
    nextCnt     = stallCnt;
    holdFront   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (RST) begin
      nextState = RUN;
      nextCnt   = 2'd0;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      nextState   = RUN;
      nextCnt     = 2'd0;
    end else if (state == STALL) begin
      holdFront   = 1'b1;
      id_ex_flush = 1'b1;
      if (stallCnt == 2'd1) begin
        nextState = RUN;
        nextCnt   = 2'd0;
      end else begin
        nextCnt = stallCnt - 2'd1;
      end
    end else if (hazard) begin
      holdFront   = 1'b1;
      id_ex_flush = 1'b1;
      if (stallLen > 2'd1) begin
        nextState = STALL;
        nextCnt   = stallLen - 2'd1;
      end
    end
  end

  assign pc_write     = !holdFront;
  assign if_id_en     = !holdFront;
  assign stall_active = holdFront;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= RUN;
      stallCnt     <= 2'd0;
      stall_cycles <= '0;
    end else begin
      state    <= nextState;
      stallCnt <= nextCnt;
      if (holdFront && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

  fwd_sel_t fwdA, fwdB;

  // A load in MEM has no data yet, so it never forwards from MEM.
  always_comb begin
    fwdA = REG;
    fwdB = REG;
    if (!RST && (FWD_EN != 0)) begin
      if (!memIsLoad && regMatch(memWr, memRd, exUses1, exRs1)) begin
        fwdA = MEM;
      end else if (regMatch(wbWr, wbRd, exUses1, exRs1)) begin
        fwdA = WB;
      end
      if (!memIsLoad && regMatch(memWr, memRd, exUses2, exRs2)) begin
        fwdB = MEM;
      end else if (regMatch(wbWr, wbRd, exUses2, exRs2)) begin
        fwdB = WB;
      end
    end
  end

  assign fwd_a = fwdA;
  assign fwd_b = fwdB;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter FWD_EN, default 1: 1 = forwarding plus load-use stall; 0 = full interlock, no forwarding.
REQ-002 Parameter LOAD_LAT, default 1, legal range 1..3: stall cycles for a load-use hazard when FWD_EN=1.
REQ-003 Parameter CNT_W, default 32: width of the stall performance counter.
REQ-004 CLK  in  1  single clock; every state element updates on the rising edge.
REQ-005 RST  in  1  reset, synchronous and active-high.
REQ-006 id_ir, ex_ir, mem_ir, wb_ir  in  32 each  instruction words currently in the ID, EX, MEM and WB stages.
REQ-007 branch_taken  in  1  the branch or jump in EX redirects the PC this cycle.
REQ-008 pc_write  out  1  PC update enable.
REQ-009 if_id_en  out  1  IF/ID register enable.
REQ-010 if_id_flush, id_ex_flush  out  1 each  load NOP 32'h00000013 into the named register.
REQ-011 fwd_a, fwd_b  out  2 each  EX operand source for rs1 and rs2: 00 register file, 01 MEM stage, 10 WB stage.
REQ-012 stall_active  out  1  high in every cycle the front end is held.
REQ-013 stall_cycles  out  CNT_W  saturating count of held cycles.

Function
REQ-014 Decoding:
- writes_rd = opcode is not 1100011 (branch) and not 0100011 (store), and rd != 0.
- uses_rs1 = opcode is not 0110111, 0010111 or 1101111.
- uses_rs2 = opcode is 0110011, 0100011 or 1100011.
- is_load = opcode 0000011.
REQ-015 A producer matches a consumer when the producer has writes_rd and its rd equals a source field the consumer uses; x0 never matches.
REQ-016 The FSM has two states: RUN and STALL.
REQ-017 FWD_EN=1, RUN: when ex_ir is a load and it matches id_ir, the unit stalls for LOAD_LAT cycles.
REQ-018 FWD_EN=0, RUN: the unit stalls when id_ir matches a producer; stall length is 3 for a match in EX, 2 in MEM, 1 in WB, and the nearest producer sets the length.
REQ-019 Detection in RUN takes effect in the same cycle, combinationally.
- Stall outputs: pc_write=0, if_id_en=0, id_ex_flush=1, stall_active=1.
- If the stall length is N>1, next state = STALL with the counter loaded to N-1.
- If N=1, the state stays RUN.
REQ-020 In STALL:
- The stall outputs of REQ-019 are held and detection is suppressed.
- The counter decrements each cycle; the state returns to RUN on the cycle the counter is 1.
REQ-021 A stall therefore holds the front end for exactly N consecutive cycles.
REQ-022 branch_taken=1 has priority in any state.
- Outputs that cycle: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_en=1, stall_active=0.
- The unit goes to RUN with counter 0, aborting any stall in progress.
REQ-023 Forwarding, FWD_EN=1:
- fwd_a = 01 when mem_ir matches rs1 of ex_ir; else 10 when wb_ir matches; else 00.
- fwd_b follows the same rule for rs2.
- MEM has priority over WB.
- A load in MEM never produces 01.
REQ-024 With FWD_EN=0, fwd_a and fwd_b are constant 00.
REQ-025 With no hazard and no branch: pc_write=1, if_id_en=1, both flush outputs 0, stall_active=0.
REQ-026 stall_cycles increments on each cycle with stall_active=1 and saturates at all-ones.

Reset
REQ-027 While RST=1 at a clock edge, the next state is RUN, the counter is 0 and stall_cycles is 0.
REQ-028 During the reset cycle, pc_write and if_id_en are 1, and both flush outputs, fwd_a, fwd_b and stall_active are 0.
REQ-029 Reset asserted mid-stall ends the stall on that edge; no residual hold follows reset.

Structure
REQ-030 Opcode constants, the NOP encoding and the fwd_sel_t enum (REG, MEM, WB) live in the shared package otter_pkg.
REQ-031 A sub-module hazard_decode maps one 32-bit IR to rd, rs1, rs2, writes_rd, uses_rs1, uses_rs2 and is_load, and is instantiated once per stage.
REQ-032 The stall counter is 2 bits wide, sufficient for a maximum stall length of 3.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- FWD_EN=1, LOAD_LAT=1: ex_ir=lw x5, id_ir=add x6,x5,x7 -> exactly 1 cycle with pc_write=0, id_ex_flush=1; stall_cycles=1.
- FWD_EN=1, LOAD_LAT=2: same pair -> 2 held cycles, then pc_write=1.
- FWD_EN=1: mem_ir=addi x3, wb_ir=addi x3, ex_ir=add x4,x3,x3 -> fwd_a=01, fwd_b=01.
- FWD_EN=0: ex_ir=addi x8, id_ir=sw x8,0(x9) -> 3 held cycles, fwd_a=fwd_b=00.
- Any stall in progress, branch_taken=1 in its second cycle -> both flushes=1, pc_write=1, and RUN on the next cycle.
- RST=1 during a stall -> the next cycle shows stall_active=0 and stall_cycles=0.
- id_ir=add x1,x0,x0 with x0 as rd in every producer -> never stalls or forwards.
